// File: rtl/vsetvl_unit_pkg.sv
// Shared types and encodings for the vector configuration unit.
package v_pkg;

  // vtype immediate as carried in zimm; vsew/vlmul occupy the low six bits
  typedef struct packed {
    logic [2:0] rsvd;
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vtype_t;

  localparam logic [2:0] LMUL_RSVD  = 3'b100;
  localparam logic [6:0] OPCODE_OP_V = 7'b1010111;
  localparam logic [2:0] FUNCT3_CFG  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/vsetvl_unit_if.sv
// Decode-side handshake plus vcsr write port of the configuration unit.
interface vsetvl_unit_if;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] cur_vl_i;
  logic        vconfig_wr_en;
  logic [31:0] vl_in;
  logic [31:0] vtype_in;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o;
  logic        vill_o;

  modport slave (
    input  instr_valid_i, instr_i, rs1_data_i, rs2_data_i, cur_vl_i,
    output instr_ready_o, vconfig_wr_en, vl_in, vtype_in,
           rd_we_o, rd_addr_o, rd_wdata_o, vill_o
  );

  modport master (
    output instr_valid_i, instr_i, rs1_data_i, rs2_data_i, cur_vl_i,
    input  instr_ready_o, vconfig_wr_en, vl_in, vtype_in,
           rd_we_o, rd_addr_o, rd_wdata_o, vill_o
  );
endinterface

// File: rtl/vsetvl_unit_vlmax_calc.sv
// Combinational VLMAX from vsew/vlmul, flagging unsupported vtype settings.
module vlmax_calc
  import v_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic [2:0]  vsew,
  input  logic [2:0]  vlmul,
  output logic [31:0] vlmax,
  output logic        illegal
);

  localparam int LOG2_VLEN = $clog2(VLEN);
  localparam int MAX_VSEW  = $clog2(ELEN / 8);

  logic signed [7:0] lmul_log2;
  logic signed [7:0] vlmax_log2;

  always_comb begin
    lmul_log2  = signed'({{5{vlmul[2]}}, vlmul});
    vlmax_log2 = signed'(8'(LOG2_VLEN)) + lmul_log2
                 - signed'({5'b0, vsew}) - 8'sd3;
    // negative log2 means fewer than one element per group
    illegal    = (vlmul == LMUL_RSVD) || (int'(vsew) > MAX_VSEW) || vlmax_log2[7];
    vlmax      = illegal ? 32'd0 : (32'd1 << unsigned'(vlmax_log2));
  end

endmodule

// File: rtl/vsetvl_unit.sv
// vsetvli/vsetivli/vsetvl executor feeding the vcsr write port.
// Optional VSETVL_BALANCE_EN: split AVL evenly when VLMAX < AVL < 2*VLMAX.
module vsetvl_unit
  import v_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  vsetvl_unit_if.slave bus
);

  state_t      state;
  logic [31:0] instr_q;
  logic [31:0] rs1_q;
  logic [10:0] rs2_q;
  logic [31:0] vl_q;
  logic [31:0] vtype_q;
  logic        vill_q;

  logic        ready_r;
  logic        wr_en_r;
  logic [31:0] vl_r;
  logic [31:0] vtype_r;
  logic        vill_r;

  logic        is_vsetvli, is_vsetivli, is_vsetvl, enc_ok;
  logic [4:0]  rs1_idx, rd_idx;
  vtype_t      zimm;
  logic [31:0] avl;
  logic [31:0] vlmax;
  logic        calc_illegal, illegal, balance;
  logic [31:0] vl_c;

  vlmax_calc #(.VLEN(VLEN), .ELEN(ELEN)) u_vlmax (
    .vsew    (zimm.vsew),
    .vlmul   (zimm.vlmul),
    .vlmax   (vlmax),
    .illegal (calc_illegal)
  );

  always_comb begin
    is_vsetvli  = ~instr_q[31];
    is_vsetivli = (instr_q[31:30] == 2'b11);
    is_vsetvl   = (instr_q[31:25] == 7'b1000000);
    enc_ok      = (instr_q[6:0] == OPCODE_OP_V) && (instr_q[14:12] == FUNCT3_CFG)
                  && (is_vsetvli || is_vsetivli || is_vsetvl);
    rs1_idx     = instr_q[19:15];
    rd_idx      = instr_q[11:7];

    zimm = vtype_t'(11'd0);
    if (is_vsetvli)       zimm = vtype_t'(instr_q[30:20]);
    else if (is_vsetivli) zimm = vtype_t'({1'b0, instr_q[29:20]});
    else if (is_vsetvl)   zimm = vtype_t'(rs2_q);

    // rs1=x0 selects max-AVL (rd!=x0) or keep-current-vl (rd=x0)
    if (is_vsetivli)        avl = {27'd0, rs1_idx};
    else if (rs1_idx != '0) avl = rs1_q;
    else if (rd_idx != '0)  avl = 32'hFFFF_FFFF;
    else                    avl = bus.cur_vl_i;

    illegal = ~enc_ok | calc_illegal | (is_vsetvl & (|zimm.rsvd));

`ifdef VSETVL_BALANCE_EN
    balance = (avl > vlmax) && ({1'b0, avl} < {vlmax, 1'b0});
`else
    balance = 1'b0;
`endif

    if (illegal)      vl_c = 32'd0;
    else if (balance) vl_c = (avl >> 1) + {31'd0, avl[0]};
    else if (avl < vlmax) vl_c = avl;
    else              vl_c = vlmax;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      instr_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      vl_q    <= '0;
      vtype_q <= '0;
      vill_q  <= 1'b0;
      ready_r <= 1'b1;
      wr_en_r <= 1'b0;
      vl_r    <= '0;
      vtype_r <= '0;
      vill_r  <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      vill_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid_i && ready_r) begin
            instr_q <= bus.instr_i;
            rs1_q   <= bus.rs1_data_i;
            rs2_q   <= bus.rs2_data_i[10:0];
            ready_r <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          vl_q    <= vl_c;
          vtype_q <= illegal ? 32'd0 : {1'b0, zimm, 20'd0};
          vill_q  <= illegal;
          state   <= WRITE;
        end
        WRITE: begin
          wr_en_r <= 1'b1;
          vl_r    <= vl_q;
          vtype_r <= vtype_q;
          vill_r  <= vill_q;
          ready_r <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready_o = ready_r;
  assign bus.vconfig_wr_en = wr_en_r;
  assign bus.rd_we_o       = wr_en_r;
  assign bus.vl_in         = vl_r;
  assign bus.rd_wdata_o    = vl_r;
  assign bus.vtype_in      = vtype_r;
  assign bus.vill_o        = vill_r;
  assign bus.rd_addr_o     = instr_q[11:7];

endmodule

// File: tb/tb_vsetvl_unit.sv
// Directed bench for vsetvl_unit with VLEN=128, ELEN=32.
module tb_vsetvl_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vsetvl_unit_if bus ();

  vsetvl_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] cur;
    logic [31:0] vl;
    logic [31:0] vtype;
    logic        vill;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] f_vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [10:0] zimm);
    return {1'b0, zimm, rs1, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic logic [31:0] f_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                             input logic [9:0] zimm);
    return {2'b11, zimm, uimm, 3'b111, rd, 7'b1010111};
  endfunction

  function automatic logic [31:0] f_vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
    return {7'b1000000, rs2, rs1, 3'b111, rd, 7'b1010111};
  endfunction

  task automatic chk(input string v, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h, expected %0h", v, what, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int waited = 0;
    @(negedge clk);
    while (bus.instr_ready_o !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk(v.name, "ready", {31'd0, bus.instr_ready_o}, 32'd1);
    bus.instr_i       = v.instr;
    bus.rs1_data_i    = v.rs1;
    bus.rs2_data_i    = v.rs2;
    bus.cur_vl_i      = v.cur;
    bus.instr_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid_i = 1'b0;
    chk(v.name, "busy", {31'd0, bus.instr_ready_o}, 32'd0);
    @(posedge clk); #1;
    chk(v.name, "early_wr", {31'd0, bus.vconfig_wr_en}, 32'd0);
    @(posedge clk); #1;
    chk(v.name, "wr_en", {31'd0, bus.vconfig_wr_en}, 32'd1);
    chk(v.name, "rd_we", {31'd0, bus.rd_we_o}, 32'd1);
    chk(v.name, "vl_in", bus.vl_in, v.vl);
    chk(v.name, "vtype_in", bus.vtype_in, v.vtype);
    chk(v.name, "vill", {31'd0, bus.vill_o}, {31'd0, v.vill});
    chk(v.name, "rd_addr", {27'd0, bus.rd_addr_o}, {27'd0, v.rd});
    chk(v.name, "rd_wdata", bus.rd_wdata_o, v.vl);
    @(posedge clk); #1;
    chk(v.name, "wr_drop", {31'd0, bus.vconfig_wr_en}, 32'd0);
    chk(v.name, "vill_drop", {31'd0, bus.vill_o}, 32'd0);
  endtask

  initial begin
    int strobes;
    int b9, b6;
`ifdef VSETVL_BALANCE_EN
    b9 = 5; b6 = 3;
`else
    b9 = 8; b6 = 4;
`endif
    vecs.push_back('{"e32m1",      f_vsetvli(2, 5, 11'h010), 20, 0, 0, 4, 32'h0100_0000, 0, 2});
    vecs.push_back('{"ivli_mf2",   f_vsetivli(3, 3, 10'h007), 0, 0, 0, 3, 32'h0070_0000, 0, 3});
    vecs.push_back('{"x0_rd1",     f_vsetvli(1, 0, 11'h00B), 32'h55, 0, 0, 64, 32'h00B0_0000, 0, 1});
    vecs.push_back('{"x0_rd0",     f_vsetvli(0, 0, 11'h00B), 32'h55, 0, 7, 7, 32'h00B0_0000, 0, 0});
    vecs.push_back('{"vl_lmul100", f_vsetvl(4, 6, 7), 10, 32'h004, 0, 0, 0, 1, 4});
    vecs.push_back('{"vl_e64",     f_vsetvl(4, 6, 7), 10, 32'h018, 0, 0, 0, 1, 4});
    vecs.push_back('{"avl0",       f_vsetvli(5, 5, 11'h010), 0, 0, 0, 0, 32'h0100_0000, 0, 5});
    vecs.push_back('{"vl_e16m1",   f_vsetvl(6, 6, 7), 100, 32'h008, 0, 8, 32'h0080_0000, 0, 6});
    vecs.push_back('{"vl_rsvd",    f_vsetvl(6, 6, 7), 100, 32'h110, 0, 0, 0, 1, 6});
    vecs.push_back('{"vli_rsvd",   f_vsetvli(7, 5, 11'h110), 3, 0, 0, 3, 32'h1100_0000, 0, 7});
    vecs.push_back('{"neg_log2",   f_vsetvli(8, 5, 11'h015), 50, 0, 0, 0, 0, 1, 8});
    vecs.push_back('{"ivli_max",   f_vsetivli(9, 31, 10'h003), 0, 0, 0, 31, 32'h0030_0000, 0, 9});
    vecs.push_back('{"vta_vma",    f_vsetvli(10, 5, 11'h0D0), 100, 0, 0, 4, 32'h0D00_0000, 0, 10});
    vecs.push_back('{"vli_lmul4",  f_vsetvli(11, 5, 11'h004), 9, 0, 0, 0, 0, 1, 11});
    vecs.push_back('{"avl_eq",     f_vsetvli(12, 5, 11'h008), 8, 0, 0, 8, 32'h0080_0000, 0, 12});
    vecs.push_back('{"avl_9",      f_vsetvli(13, 5, 11'h008), 9, 0, 0, b9, 32'h0080_0000, 0, 13});
    vecs.push_back('{"avl_15",     f_vsetvli(14, 5, 11'h008), 15, 0, 0, 8, 32'h0080_0000, 0, 14});
    vecs.push_back('{"avl_6",      f_vsetvli(15, 5, 11'h010), 6, 0, 0, b6, 32'h0100_0000, 0, 15});
    vecs.push_back('{"ivli_zero",  f_vsetivli(0, 0, 10'h010), 0, 0, 9, 0, 32'h0100_0000, 0, 0});

    rst = 1'b1;
    bus.instr_valid_i = 1'b0;
    bus.instr_i = '0;
    bus.rs1_data_i = '0;
    bus.rs2_data_i = '0;
    bus.cur_vl_i = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", "ready", {31'd0, bus.instr_ready_o}, 32'd1);
    chk("reset", "wr_en", {31'd0, bus.vconfig_wr_en}, 32'd0);
    chk("reset", "rd_we", {31'd0, bus.rd_we_o}, 32'd0);
    chk("reset", "vl_in", bus.vl_in, 32'd0);
    chk("reset", "vtype_in", bus.vtype_in, 32'd0);
    chk("reset", "rd_addr", {27'd0, bus.rd_addr_o}, 32'd0);
    chk("reset", "rd_wdata", bus.rd_wdata_o, 32'd0);
    chk("reset", "vill", {31'd0, bus.vill_o}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // reset while in CALC: no strobe may follow
    @(negedge clk);
    bus.instr_i = vecs[0].instr;
    bus.rs1_data_i = 20;
    bus.instr_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid_i = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    strobes = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.vconfig_wr_en === 1'b1) strobes++;
    end
    chk("rst_calc", "strobes", strobes, 32'd0);
    chk("rst_calc", "ready", {31'd0, bus.instr_ready_o}, 32'd1);

    // reset while the strobe is high: it drops at once
    @(negedge clk);
    bus.instr_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rst_write", "wr_en_before", {31'd0, bus.vconfig_wr_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_write", "wr_en_after", {31'd0, bus.vconfig_wr_en}, 32'd0);
    chk("rst_write", "rd_we_after", {31'd0, bus.rd_we_o}, 32'd0);
    #1 rst = 1'b0;

    // valid held high across busy: accepts at edges 0,3,6 -> strobes after 2,5,8
    @(negedge clk);
    bus.instr_valid_i = 1'b1;
    strobes = 0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (bus.vconfig_wr_en === 1'b1) strobes++;
      if (c == 8) chk("hold_valid", "last_strobe", {31'd0, bus.vconfig_wr_en}, 32'd1);
    end
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    chk("hold_valid", "strobes", strobes, 32'd3);
    @(posedge clk); #1;
    chk("hold_valid", "idle", {31'd0, bus.vconfig_wr_en}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
